fd_frame_sched: RTL and testbench

- Frame-level scheduler for the face-detection pipeline.
- Owns the ping-pong bank selection of the 80x60 output memory (OM) shared by the capture writer and the moving-window reader.
- Launches the moving-window controller with a pulse, then launches the classifier once window output is ready.
- Handles back-pressure from capture (at most one pending frame), counts completed and dropped frames, and aborts a stalled frame through a watchdog.

---
 rtl/fd_sched_pkg.sv | 21 ++
 rtl/fd_watchdog.sv | 32 +++
 rtl/fd_frame_sched.sv | 119 +++++++++++
 tb/tb_fd_frame_sched.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fd_sched_pkg.sv
// Shared constants for the face-detection frame scheduler: FSM encoding,
// output-memory geometry and default counter widths.
package fd_sched_pkg;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE = 2'd0;
    localparam sched_state_t ST_MV   = 2'd1;
    localparam sched_state_t ST_CLS  = 2'd2;
    localparam sched_state_t ST_DONE = 2'd3;

    // Output memory is one 80x60 bank per frame, two banks ping-ponged.
    localparam int          OM_ADDR_W    = 13;
    localparam logic [12:0] FRAME_PIXELS = 13'd4800;

    localparam int          DEF_TO_W        = 20;
    localparam int          DEF_FCNT_W      = 16;
    localparam int          DEF_DCNT_W      = 8;
    localparam logic [19:0] DEF_TIMEOUT_CYC = 20'd1000000;

endpackage

// File: rtl/fd_watchdog.sv
// Per-stage cycle counter: cleared on stage entry, counts while enabled and
// flags the cycle in which the count sits at TIMEOUT_CYC-1.
module fd_watchdog #(
    parameter int                TO_W        = 20,
    parameter logic [TO_W-1:0]   TIMEOUT_CYC = 20'd1000000
) (
    input  logic iClk,
    input  logic iReset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [TO_W-1:0] TERM_CNT = TIMEOUT_CYC - 1'b1;

    logic [TO_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every always_ff sees the pre-edge value of every other register.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != TERM_CNT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign terminal = enable && (cnt == TERM_CNT);

endmodule

// File: rtl/fd_frame_sched.sv
// Frame scheduler: owns the OM ping-pong banks, launches the window controller
// and classifier, buffers one pending frame and aborts stalled stages.
module fd_frame_sched
    import fd_sched_pkg::*;
#(
    parameter int              TO_W        = DEF_TO_W,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 20'd1000000,
    parameter int              FCNT_W      = DEF_FCNT_W,
    parameter int              DCNT_W      = DEF_DCNT_W
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iEnable,
    input  logic              iFrame_start,
    input  logic              iFrame_done,
    input  logic              iMV_ready,
    input  logic              iCls_done,
    input  logic              iClr_err,
    output logic              oRun_MV,
    output logic              oRun_cls,
    output logic              oWr_bank,
    output logic              oRd_bank,
    output logic              oCap_allow,
    output logic              oBusy,
    output logic [1:0]        oState,
    output logic [FCNT_W-1:0] oFrame_cnt,
    output logic [DCNT_W-1:0] oDrop_cnt,
    output logic              oTimeout
);

    sched_state_t state;
    logic         pending;
    logic         launch;
    logic         mv_to_cls;
    logic         cls_finish;
    logic         wd_term;
    logic         timeout_hit;

    assign oCap_allow  = ~pending;
    assign launch      = (state == ST_IDLE) && iEnable
                         && (pending || (iFrame_done && oCap_allow));
    assign mv_to_cls   = (state == ST_MV) && iMV_ready;
    assign cls_finish  = (state == ST_CLS) && iCls_done;
    // The awaited pulse beats the watchdog when both land in the terminal cycle.
    assign timeout_hit = wd_term && !mv_to_cls && !cls_finish;

    fd_watchdog #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .clear    (launch || mv_to_cls),
        .enable   ((state == ST_MV) || (state == ST_CLS)),
        .terminal (wd_term)
    );

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state      <= ST_IDLE;
            oWr_bank   <= 1'b0;
            oRd_bank   <= 1'b1;
            oRun_MV    <= 1'b0;
            oRun_cls   <= 1'b0;
            oFrame_cnt <= '0;
        end else begin
            oRun_MV  <= launch;
            oRun_cls <= mv_to_cls;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        oRd_bank <= oWr_bank;
                        oWr_bank <= ~oWr_bank;
                        state    <= ST_MV;
                    end
                end
                ST_MV: begin
                    if (iMV_ready)    state <= ST_CLS;
                    else if (wd_term) state <= ST_IDLE;
                end
                ST_CLS: begin
                    if (iCls_done) begin
                        oFrame_cnt <= oFrame_cnt + 1'b1;
                        state      <= ST_DONE;
                    end else if (wd_term) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Back-pressure: one frame may wait; starts arriving while it waits are dropped.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            pending   <= 1'b0;
            oDrop_cnt <= '0;
            oTimeout  <= 1'b0;
        end else begin
            if (launch)
                pending <= 1'b0;
            else if (iFrame_done && oCap_allow)
                pending <= 1'b1;

            if (iFrame_start && !oCap_allow && (oDrop_cnt != '1))
                oDrop_cnt <= oDrop_cnt + 1'b1;

            if (timeout_hit)
                oTimeout <= 1'b1;
            else if (iClr_err)
                oTimeout <= 1'b0;
        end
    end

    assign oBusy  = (state != ST_IDLE);
    assign oState = state;

endmodule

// File: tb/tb_fd_frame_sched.sv
// Directed bench for fd_frame_sched with a 100-cycle watchdog; each task drives
// one scenario and compares outputs against hand-derived values.
module tb_fd_frame_sched;

    localparam int          TO_W   = 20;
    localparam logic [19:0] TO_CYC = 20'd100;

    logic        iClk;
    logic        iReset_n;
    logic        iEnable;
    logic        iFrame_start;
    logic        iFrame_done;
    logic        iMV_ready;
    logic        iCls_done;
    logic        iClr_err;
    logic        oRun_MV;
    logic        oRun_cls;
    logic        oWr_bank;
    logic        oRd_bank;
    logic        oCap_allow;
    logic        oBusy;
    logic [1:0]  oState;
    logic [15:0] oFrame_cnt;
    logic [7:0]  oDrop_cnt;
    logic        oTimeout;

    // {state[1:0], wr, rd, cap_allow, busy, run_mv, run_cls, timeout}
    logic [8:0]  status;
    assign status = {oState, oWr_bank, oRd_bank, oCap_allow, oBusy, oRun_MV, oRun_cls, oTimeout};

    int checks = 0;
    int errors = 0;

    fd_frame_sched #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TO_CYC),
        .FCNT_W      (16),
        .DCNT_W      (8)
    ) dut (
        .iClk         (iClk),
        .iReset_n     (iReset_n),
        .iEnable      (iEnable),
        .iFrame_start (iFrame_start),
        .iFrame_done  (iFrame_done),
        .iMV_ready    (iMV_ready),
        .iCls_done    (iCls_done),
        .iClr_err     (iClr_err),
        .oRun_MV      (oRun_MV),
        .oRun_cls     (oRun_cls),
        .oWr_bank     (oWr_bank),
        .oRd_bank     (oRd_bank),
        .oCap_allow   (oCap_allow),
        .oBusy        (oBusy),
        .oState       (oState),
        .oFrame_cnt   (oFrame_cnt),
        .oDrop_cnt    (oDrop_cnt),
        .oTimeout     (oTimeout)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Advance n clock edges, then settle 1 time unit so outputs are stable.
    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iReset_n = 1'b0; iEnable = 1'b0; iFrame_start = 1'b0; iFrame_done = 1'b0;
        iMV_ready = 1'b0; iCls_done = 1'b0; iClr_err = 1'b0;
        tick(2);
        iReset_n = 1'b1;
        checks++; if (status !== 9'b00_0_1_1_0_0_0_0) begin errors++; $display("FAIL reset_status: got %b expected %b", status, 9'b000110000); end
        checks++; if (oFrame_cnt !== 16'd0) begin errors++; $display("FAIL reset_fcnt: got %0d expected 0", oFrame_cnt); end
        checks++; if (oDrop_cnt !== 8'd0) begin errors++; $display("FAIL reset_dcnt: got %0d expected 0", oDrop_cnt); end
    endtask

    task automatic test_launch();
        iEnable = 1'b1;
        iFrame_done = 1'b1; tick(1); iFrame_done = 1'b0;
        checks++; if (status !== 9'b01_1_0_1_1_1_0_0) begin errors++; $display("FAIL launch_status: got %b expected %b", status, 9'b011011100); end
        tick(1);
        checks++; if (status !== 9'b01_1_0_1_1_0_0_0) begin errors++; $display("FAIL launch_pulse_width: got %b expected %b", status, 9'b011011000); end
    endtask

    task automatic test_full_frame();
        tick(48);
        iMV_ready = 1'b1; tick(1); iMV_ready = 1'b0;
        checks++; if (status !== 9'b10_1_0_1_1_0_1_0) begin errors++; $display("FAIL frame_run_cls: got %b expected %b", status, 9'b101011010); end
        tick(1);
        checks++; if (oRun_cls !== 1'b0) begin errors++; $display("FAIL frame_run_cls_width: got %b expected 0", oRun_cls); end
        iCls_done = 1'b1; tick(1); iCls_done = 1'b0;
        checks++; if (status !== 9'b11_1_0_1_1_0_0_0) begin errors++; $display("FAIL frame_done_state: got %b expected %b", status, 9'b111011000); end
        checks++; if (oFrame_cnt !== 16'd1) begin errors++; $display("FAIL frame_cnt1: got %0d expected 1", oFrame_cnt); end
        tick(1);
        checks++; if (status !== 9'b00_1_0_1_0_0_0_0) begin errors++; $display("FAIL frame_idle: got %b expected %b", status, 9'b001010000); end
    endtask

    task automatic test_back_to_back();
        iFrame_done = 1'b1; tick(1); iFrame_done = 1'b0;
        checks++; if (status !== 9'b01_0_1_1_1_1_0_0) begin errors++; $display("FAIL b2b_launch: got %b expected %b", status, 9'b010111100); end
        iFrame_done = 1'b1; tick(1); iFrame_done = 1'b0;
        checks++; if (status !== 9'b01_0_1_0_1_0_0_0) begin errors++; $display("FAIL b2b_pending: got %b expected %b", status, 9'b010101000); end
        iMV_ready = 1'b1; tick(1); iMV_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iFrame_start = 1'b1; tick(1); iFrame_start = 1'b0; tick(1);
        end
        // Frame-done while back-pressured must not alter anything.
        iFrame_done = 1'b1; tick(1); iFrame_done = 1'b0;
        checks++; if (oDrop_cnt !== 8'd3) begin errors++; $display("FAIL b2b_drop3: got %0d expected 3", oDrop_cnt); end
        checks++; if (status !== 9'b10_0_1_0_1_0_0_0) begin errors++; $display("FAIL b2b_cls: got %b expected %b", status, 9'b100101000); end
        iCls_done = 1'b1; tick(1); iCls_done = 1'b0;
        checks++; if (status !== 9'b11_0_1_0_1_0_0_0) begin errors++; $display("FAIL b2b_done: got %b expected %b", status, 9'b110101000); end
        tick(1);
        checks++; if (status !== 9'b00_0_1_0_0_0_0_0) begin errors++; $display("FAIL b2b_idle: got %b expected %b", status, 9'b000100000); end
        tick(1);
        checks++; if (status !== 9'b01_1_0_1_1_1_0_0) begin errors++; $display("FAIL b2b_relaunch: got %b expected %b", status, 9'b011011100); end
        iMV_ready = 1'b1; tick(1); iMV_ready = 1'b0;
        iCls_done = 1'b1; tick(1); iCls_done = 1'b0;
        tick(1);
        checks++; if (oFrame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_fcnt3: got %0d expected 3", oFrame_cnt); end
        checks++; if (status !== 9'b00_1_0_1_0_0_0_0) begin errors++; $display("FAIL b2b_end_idle: got %b expected %b", status, 9'b001010000); end
    endtask

    task automatic test_timeout();
        iFrame_done = 1'b1; tick(1); iFrame_done = 1'b0;
        tick(99);
        checks++; if (status !== 9'b01_0_1_1_1_0_0_0) begin errors++; $display("FAIL to_before: got %b expected %b", status, 9'b010111000); end
        tick(1);
        checks++; if (status !== 9'b00_0_1_1_0_0_0_1) begin errors++; $display("FAIL to_fire: got %b expected %b", status, 9'b000110001); end
        checks++; if (oFrame_cnt !== 16'd3) begin errors++; $display("FAIL to_fcnt: got %0d expected 3", oFrame_cnt); end
        tick(3);
        checks++; if (oTimeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", oTimeout); end
        iClr_err = 1'b1; tick(1); iClr_err = 1'b0;
        checks++; if (oTimeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", oTimeout); end
    endtask

    task automatic test_pulse_wins();
        iFrame_done = 1'b1; tick(1); iFrame_done = 1'b0;
        tick(99);
        iMV_ready = 1'b1; tick(1); iMV_ready = 1'b0;
        checks++; if (status !== 9'b10_1_0_1_1_0_1_0) begin errors++; $display("FAIL pw_cls: got %b expected %b", status, 9'b101011010); end
        iCls_done = 1'b1; tick(1); iCls_done = 1'b0;
        tick(1);
        checks++; if (oFrame_cnt !== 16'd4) begin errors++; $display("FAIL pw_fcnt4: got %0d expected 4", oFrame_cnt); end
        checks++; if (status !== 9'b00_1_0_1_0_0_0_0) begin errors++; $display("FAIL pw_idle: got %b expected %b", status, 9'b001010000); end
    endtask

    task automatic test_saturation_enable();
        logic saw_launch;
        saw_launch = 1'b0;
        iEnable = 1'b0;
        iFrame_done = 1'b1; tick(1); iFrame_done = 1'b0;
        checks++; if (status !== 9'b00_1_0_0_0_0_0_0) begin errors++; $display("FAIL sat_pending: got %b expected %b", status, 9'b001000000); end
        for (int i = 0; i < 300; i++) begin
            iFrame_start = 1'b1; tick(1); iFrame_start = 1'b0; tick(1);
            if (oRun_MV || oBusy) saw_launch = 1'b1;
        end
        checks++; if (oDrop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop: got %0d expected 255", oDrop_cnt); end
        checks++; if (saw_launch !== 1'b0) begin errors++; $display("FAIL sat_no_launch: got %b expected 0", saw_launch); end
        iEnable = 1'b1; tick(1);
        checks++; if (status !== 9'b01_0_1_1_1_1_0_0) begin errors++; $display("FAIL sat_enable_launch: got %b expected %b", status, 9'b010111100); end
    endtask

    task automatic test_mid_reset();
        iMV_ready = 1'b1; tick(1); iMV_ready = 1'b0;
        iFrame_done = 1'b1; tick(1); iFrame_done = 1'b0;
        checks++; if (status !== 9'b10_0_1_0_1_0_0_0) begin errors++; $display("FAIL mr_cls: got %b expected %b", status, 9'b100101000); end
        iReset_n = 1'b0; tick(1); iReset_n = 1'b1;
        checks++; if (status !== 9'b00_0_1_1_0_0_0_0) begin errors++; $display("FAIL mr_status: got %b expected %b", status, 9'b000110000); end
        checks++; if ({oFrame_cnt, oDrop_cnt} !== 24'd0) begin errors++; $display("FAIL mr_counters: got %0d/%0d expected 0/0", oFrame_cnt, oDrop_cnt); end
        iCls_done = 1'b1; tick(1); iCls_done = 1'b0;
        iMV_ready = 1'b1; tick(1); iMV_ready = 1'b0;
        checks++; if (status !== 9'b00_0_1_1_0_0_0_0) begin errors++; $display("FAIL mr_ignore: got %b expected %b", status, 9'b000110000); end
        checks++; if (oFrame_cnt !== 16'd0) begin errors++; $display("FAIL mr_fcnt: got %0d expected 0", oFrame_cnt); end
    endtask

    initial begin
        #2;
        test_reset();
        test_launch();
        test_full_frame();
        test_back_to_back();
        test_timeout();
        test_pulse_wins();
        test_saturation_enable();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
